fios_result_collector: RTL and testbench
========================================

Name: fios_result_collector

Overview:
- Receiving end of the PE chain's result stream.
- Captures the 17-bit words emitted by the last FIOS processing element, one per strobe, least-significant word first.
- Reassembles them into a WORD_COUNT-word Montgomery product and presents it with a valid/ready handshake to the host-side wrapper.
- Sits between the PE chain and the top-level result register or AXI adapter.

Parameters:
WORD_WIDTH, 17, width of one result word (DSP A/B operand width)
WORD_COUNT, 8, number of result words per product; result width = WORD_COUNT*WORD_WIDTH

Ports:
clock_i  input  1  single clock; all state updates on rising edge
reset_i  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle pulse arming collection of a new product
res_valid_i  input  1  res_i (and p_i) carry a valid word this cycle
res_i  input  WORD_WIDTH  result word from last PE (RES_o of chain)
p_i  input  WORD_WIDTH  modulus word of same index as res_i (used only with FINAL_SUB_EN)
result_o  output  WORD_COUNT*WORD_WIDTH  assembled product, word 0 at LSBs
result_valid_o  output  1  result_o valid; held until accepted
result_ready_i  input  1  consumer accepts result_o when high with result_valid_o
busy_o  output  1  high in COLLECT or DONE
overrun_o  output  1  sticky: word arrived while result not yet accepted

Behaviour:
- Reset (async, active-high): state=IDLE, word counter=0, result_o=0, result_valid_o=0, busy_o=0, overrun_o=0.
- State machine has three states: IDLE, COLLECT, DONE.
- IDLE:
  - res_valid_i is ignored.
  - start_i -> COLLECT, counter=0, overrun_o cleared.
- COLLECT:
  - Each cycle with res_valid_i: res_i is written to word slot[counter], counter++.
  - Valid word with counter==WORD_COUNT-1 -> DONE; result_valid_o=1 on the next cycle (latency 1 after the last word).
  - Gaps in res_valid_i are allowed; the counter holds.
  - start_i in COLLECT restarts: counter=0, partial words are discarded.
  - start_i and res_valid_i in the same cycle: start wins and the word is dropped.
- DONE:
  - result_o is stable; result_valid_o=1.
  - result_valid_o & result_ready_i -> IDLE; result_valid_o=0 next cycle.
  - start_i in the same cycle as the handshake -> COLLECT directly (back-to-back products, no idle cycle).
  - start_i without result_ready_i is ignored.
  - res_valid_i in DONE sets overrun_o; the word is dropped and result_o is unchanged.
- busy_o = (state != IDLE), registered.
- Async reset mid-COLLECT or mid-DONE: immediate return to IDLE with all outputs at their reset values; partial data is lost.
- Counter width = clog2(WORD_COUNT); no wrap occurs because DONE is entered at WORD_COUNT-1.

Optional Feature:
- Macro: FIOS_FINAL_SUB_EN.
- Defined:
  - Word-serial conditional subtraction result - p is computed alongside collection.
  - Per valid word: diff slot[counter] = res_i - p_i - borrow, with a registered borrow (cleared on start_i).
  - On the last word, the final borrow selects the output. Borrow=0 (result>=p) -> result_o is the diff words; otherwise result_o is the raw words.
  - Selection is registered on DONE entry; latency is unchanged.
  - The block relies on the PE chain guaranteeing result < 2p.
- Undefined: p_i is unused; result_o is the raw words; no diff storage is synthesized.

Decomposition:
- Shared package fios_pkg:
  - WORD_WIDTH default constant.
  - State enum typedef collector_state_t {IDLE, COLLECT, DONE}.
  - Function word_count_bits(n) = clog2.
- One natural sub-module: fios_word_subtractor, a 17-bit subtract with borrow-in/borrow-out and a registered borrow. It is instantiated only under FIOS_FINAL_SUB_EN.

Test Plan:
1. WORD_COUNT=4, start, then words 0x00001,0x00002,0x00003,0x00004 on consecutive cycles -> result_valid_o one cycle after the 4th word, result_o=0x00004_00003_00002_00001 (17-bit fields).
2. Same words with a 2-cycle res_valid_i gap after word 1, result_ready_i held low for 5 cycles -> result_o stable, result_valid_o high throughout, IDLE after the handshake.
3. In DONE, pulse res_valid_i with 0x1FFFF -> overrun_o=1, result_o unchanged; next start_i clears overrun_o.
4. start_i after 2 words, then 4 new words 0x10,0x20,0x30,0x40 -> result_o built only from the new words.
5. Async reset asserted after word 2 -> outputs zero immediately; start plus 4 words afterwards completes normally.
6. FIOS_FINAL_SUB_EN, p words {5,0,0,0}: result {7,0,0,0} -> result_o word0=2; result {3,0,0,0} -> result_o word0=3 (borrow, raw kept).

Source files
------------

// File: rtl/fios_pkg.sv
// Shared types and constants for the FIOS Montgomery result path.
package fios_pkg;

    localparam int DEFAULT_WORD_WIDTH = 17;
    localparam int DEFAULT_WORD_COUNT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collector_state_t;

    // A counter is always at least one bit wide, even for a single-word product.
    function automatic int word_count_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fios_word_subtractor.sv
// Word-serial subtractor: diff = a - b - borrow, where the borrow is carried between words in a register.
module fios_word_subtractor
    import fios_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    output logic [WORD_WIDTH-1:0] diff_o,
    output logic                  borrow_o
);

    logic                borrow_q, borrow_d;
    logic [WORD_WIDTH:0] full_diff;

    // The extra top bit of the widened difference is the borrow out of this word.
    always_comb begin
        full_diff = {1'b0, a_i} - {1'b0, b_i} - {{WORD_WIDTH{1'b0}}, borrow_q};
        diff_o    = full_diff[WORD_WIDTH-1:0];
        borrow_o  = full_diff[WORD_WIDTH];
        borrow_d  = borrow_q;
        if (clear_i) begin
            borrow_d = 1'b0;
        end else if (en_i) begin
            borrow_d = full_diff[WORD_WIDTH];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= borrow_d;
        end
    end

endmodule

// File: rtl/fios_result_collector.sv
// Reassembles the PE chain's word-serial result stream into one product and hands it over via valid/ready.
// Define FIOS_FINAL_SUB_EN to add the word-serial conditional final subtraction of p.
module fios_result_collector
    import fios_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int WORD_COUNT = DEFAULT_WORD_COUNT
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic                             res_valid_i,
    input  logic [WORD_WIDTH-1:0]            res_i,
    input  logic [WORD_WIDTH-1:0]            p_i,
    output logic [WORD_COUNT*WORD_WIDTH-1:0] result_o,
    output logic                             result_valid_o,
    input  logic                             result_ready_i,
    output logic                             busy_o,
    output logic                             overrun_o
);

    localparam int CW = word_count_bits(WORD_COUNT);
    localparam int RW = WORD_COUNT * WORD_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_COUNT - 1);

    collector_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    raw_q, raw_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             word_we;
    logic             last_word;

    assign last_word = (cnt_q == LAST_IDX);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            raw_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            raw_q     <= raw_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // A start in DONE only counts when the handshake completes in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = COLLECT;
            end
            COLLECT: begin
                if (!start_i && res_valid_i && last_word) state_d = DONE;
            end
            DONE: begin
                if (valid_q && result_ready_i) state_d = start_i ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        raw_d     = raw_q;
        overrun_d = overrun_q;
        word_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            COLLECT: begin
                if (start_i) begin
                    cnt_d = '0;
                end else if (res_valid_i) begin
                    word_we = 1'b1;
                    raw_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = res_i;
                    cnt_d = last_word ? '0 : cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_valid_i) overrun_d = 1'b1;
                if (valid_q && result_ready_i && start_i) begin
                    cnt_d     = '0;
                    overrun_d = 1'b0;
                end
            end
            default: ;
        endcase
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    assign result_valid_o = valid_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;

`ifdef FIOS_FINAL_SUB_EN
    logic [WORD_WIDTH-1:0] diff_word;
    logic                  borrow_out;
    logic [RW-1:0]         diff_q, diff_d;
    logic                  sel_diff_q, sel_diff_d;

    fios_word_subtractor #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_sub (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (start_i),
        .en_i    (word_we),
        .a_i     (res_i),
        .b_i     (p_i),
        .diff_o  (diff_word),
        .borrow_o(borrow_out)
    );

    // No final borrow means result >= p, so the reduced words are the answer.
    always_comb begin
        diff_d     = diff_q;
        sel_diff_d = sel_diff_q;
        if (word_we) begin
            diff_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = diff_word;
            if (last_word) sel_diff_d = ~borrow_out;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            diff_q     <= '0;
            sel_diff_q <= 1'b0;
        end else begin
            diff_q     <= diff_d;
            sel_diff_q <= sel_diff_d;
        end
    end

    assign result_o = sel_diff_q ? diff_q : raw_q;
`else
    logic unused_p;
    assign unused_p = ^p_i;
    assign result_o = raw_q;
`endif

endmodule

// File: tb/tb_fios_result_collector.sv
// Directed self-checking bench for fios_result_collector with a 4-word product.
module tb_fios_result_collector;

   localparam int WW = 17;
   localparam int WC = 4;
   localparam int RW = WW * WC;

   logic          clock;
   logic          reset;
   logic          startIn;
   logic          resValid;
   logic [WW-1:0] resIn;
   logic [WW-1:0] pIn;
   logic [RW-1:0] resultOut;
   logic          resultValid;
   logic          resultReady;
   logic          busyOut;
   logic          overrunOut;

   int            checks;
   int            errors;
   logic [RW-1:0] expected;

   fios_result_collector #(
      .WORD_WIDTH(WW),
      .WORD_COUNT(WC)
   ) dut (
      .clock_i       (clock),
      .reset_i       (reset),
      .start_i       (startIn),
      .res_valid_i   (resValid),
      .res_i         (resIn),
      .p_i           (pIn),
      .result_o      (resultOut),
      .result_valid_o(resultValid),
      .result_ready_i(resultReady),
      .busy_o        (busyOut),
      .overrun_o     (overrunOut)
   );

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it, so sampling never races the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic sendWord(input logic [WW-1:0] w, input logic [WW-1:0] p);
      resValid = 1'b1;
      resIn    = w;
      pIn      = p;
      tick();
      resValid = 1'b0;
   endtask

   task automatic pulseStart();
      startIn = 1'b1;
      tick();
      startIn = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++;
      if (resultValid !== 1'b0 || busyOut !== 1'b0 || overrunOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: valid=%b busy=%b overrun=%b expected 0 0 0", resultValid, busyOut, overrunOut);
      end
      checks++;
      if (resultOut !== '0) begin
         errors++;
         $display("[TB] FAIL reset_result: got %h expected 0", resultOut);
      end
      reset = 1'b0;
      tick();
      sendWord(17'h1ABCD, 17'h0);
      checks++;
      if (busyOut !== 1'b0 || resultOut !== '0) begin
         errors++;
         $display("[TB] FAIL idle_ignores_word: busy=%b result=%h expected 0 and 0", busyOut, resultOut);
      end
   endtask

   task automatic test_basic();
      expected = {17'd4, 17'd3, 17'd2, 17'd1};
      pulseStart();
      checks++;
      if (busyOut !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_busy: got %b expected 1", busyOut);
      end
      sendWord(17'd1, 17'd0);
      sendWord(17'd2, 17'd0);
      sendWord(17'd3, 17'd0);
      checks++;
      if (resultValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_early_valid: got %b expected 0", resultValid);
      end
      sendWord(17'd4, 17'd0);
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL basic_result: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
      checks++;
      if (resultValid !== 1'b0 || busyOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_handshake: valid=%b busy=%b expected 0 0", resultValid, busyOut);
      end
   endtask

   task automatic test_gap_backpressure();
      expected = {17'd4, 17'd3, 17'd2, 17'd1};
      pulseStart();
      sendWord(17'd1, 17'd0);
      tick();
      tick();
      sendWord(17'd2, 17'd0);
      sendWord(17'd3, 17'd0);
      checks++;
      if (resultValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gap_early_valid: got %b expected 0", resultValid);
      end
      sendWord(17'd4, 17'd0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (resultValid !== 1'b1 || resultOut !== expected) begin
            errors++;
            $display("[TB] FAIL gap_hold[%0d]: valid=%b result=%h expected 1 %h", i, resultValid, resultOut, expected);
         end
         tick();
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
      checks++;
      if (resultValid !== 1'b0 || busyOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gap_idle: valid=%b busy=%b expected 0 0", resultValid, busyOut);
      end
   endtask

   task automatic test_overrun_back_to_back();
      expected = {17'd4, 17'd3, 17'd2, 17'd1};
      pulseStart();
      sendWord(17'd1, 17'd0);
      sendWord(17'd2, 17'd0);
      sendWord(17'd3, 17'd0);
      sendWord(17'd4, 17'd0);
      sendWord(17'h1FFFF, 17'd0);
      checks++;
      if (overrunOut !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_set: got %b expected 1", overrunOut);
      end
      checks++;
      if (resultOut !== expected || resultValid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_result: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      startIn     = 1'b1;
      resultReady = 1'b1;
      tick();
      startIn     = 1'b0;
      resultReady = 1'b0;
      checks++;
      if (overrunOut !== 1'b0 || busyOut !== 1'b1 || resultValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_restart: overrun=%b busy=%b valid=%b expected 0 1 0", overrunOut, busyOut, resultValid);
      end
      expected = {17'd8, 17'd7, 17'd6, 17'd5};
      sendWord(17'd5, 17'd0);
      sendWord(17'd6, 17'd0);
      sendWord(17'd7, 17'd0);
      sendWord(17'd8, 17'd0);
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL b2b_result: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      startIn = 1'b1;
      tick();
      startIn = 1'b0;
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL done_start_ignored: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
   endtask

   task automatic test_restart();
      expected = {17'h40, 17'h30, 17'h20, 17'h10};
      pulseStart();
      sendWord(17'hAA, 17'd0);
      sendWord(17'hBB, 17'd0);
      startIn  = 1'b1;
      resValid = 1'b1;
      resIn    = 17'h99;
      tick();
      startIn  = 1'b0;
      resValid = 1'b0;
      sendWord(17'h10, 17'd0);
      sendWord(17'h20, 17'd0);
      sendWord(17'h30, 17'd0);
      checks++;
      if (resultValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL restart_early_valid: got %b expected 0", resultValid);
      end
      sendWord(17'h40, 17'd0);
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL restart_result: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
   endtask

   task automatic test_async_reset();
      pulseStart();
      sendWord(17'h11, 17'd0);
      sendWord(17'h22, 17'd0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (resultOut !== '0 || busyOut !== 1'b0 || resultValid !== 1'b0 || overrunOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset: result=%h busy=%b valid=%b overrun=%b expected all 0", resultOut, busyOut, resultValid, overrunOut);
      end
      #3;
      reset = 1'b0;
      tick();
      expected = {17'd4, 17'd3, 17'd2, 17'd1};
      pulseStart();
      sendWord(17'd1, 17'd0);
      sendWord(17'd2, 17'd0);
      sendWord(17'd3, 17'd0);
      sendWord(17'd4, 17'd0);
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL after_reset_result: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
   endtask

   task automatic test_final_sub();
      // Without the subtraction feature the raw words always come through and p is ignored.
`ifdef FIOS_FINAL_SUB_EN
      expected = {17'd0, 17'd0, 17'd0, 17'd2};
`else
      expected = {17'd0, 17'd0, 17'd0, 17'd7};
`endif
      pulseStart();
      sendWord(17'd7, 17'd5);
      sendWord(17'd0, 17'd0);
      sendWord(17'd0, 17'd0);
      sendWord(17'd0, 17'd0);
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL finalsub_ge: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
      expected = {17'd0, 17'd0, 17'd0, 17'd3};
      pulseStart();
      sendWord(17'd3, 17'd5);
      sendWord(17'd0, 17'd0);
      sendWord(17'd0, 17'd0);
      sendWord(17'd0, 17'd0);
      checks++;
      if (resultValid !== 1'b1 || resultOut !== expected) begin
         errors++;
         $display("[TB] FAIL finalsub_lt: valid=%b result=%h expected 1 %h", resultValid, resultOut, expected);
      end
      resultReady = 1'b1;
      tick();
      resultReady = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      startIn     = 1'b0;
      resValid    = 1'b0;
      resIn       = '0;
      pIn         = '0;
      resultReady = 1'b0;
      test_reset();
      test_basic();
      test_gap_backpressure();
      test_overrun_back_to_back();
      test_restart();
      test_async_reset();
      test_final_sub();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
